// File: rtl/axi_cmp_pkg.sv
// Shared definitions for the AXI write-channel lockstep comparator.
//   - Channel indices into per-channel vectors (AW, W, B).
//   - AXI burst type encodings.
//   - Payload width helpers, plus default-width localparams for AW=32, LENW=8, DW=64.
package axi_cmp_pkg;

  localparam int unsigned CH_AW  = 0;
  localparam int unsigned CH_W   = 1;
  localparam int unsigned CH_B   = 2;
  localparam int unsigned NUM_CH = 3;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_e;

  // AW payload = {addr, len, size[2:0], burst[1:0]}
  function automatic int unsigned aw_pl_width(input int unsigned aw, input int unsigned lenw);
    return aw + lenw + 5;
  endfunction

  // W payload = {data, strb, last}
  function automatic int unsigned w_pl_width(input int unsigned dw);
    return dw + dw / 8 + 1;
  endfunction

  // B payload = {resp}
  function automatic int unsigned b_pl_width();
    return 2;
  endfunction

  // Capture register width: the widest of the three payloads.
  function automatic int unsigned cap_width(input int unsigned aw, input int unsigned lenw,
                                            input int unsigned dw);
    int unsigned w;
    w = aw_pl_width(aw, lenw);
    if (w_pl_width(dw) > w) w = w_pl_width(dw);
    if (b_pl_width() > w) w = b_pl_width();
    return w;
  endfunction

  localparam int unsigned AW_PL_W = aw_pl_width(32, 8);
  localparam int unsigned W_PL_W  = w_pl_width(64);
  localparam int unsigned B_PL_W  = b_pl_width();

endpackage

// File: rtl/axi_wr_lockstep_cmp_chan.sv
// cmp_chan: one channel of the lockstep comparator.
// Two DEPTH-entry FIFOs (side A, side B) absorb timing skew. When both heads
// are valid they are compared combinationally and popped together.
// Ports:
//   clk, resetn       clock, async active-low reset (flushes both FIFOs)
//   a_push, a_pl      side A handshake and payload
//   b_push, b_pl      side B handshake and payload
//   mism              this cycle's compare found a difference
//   ovf               a push hit a full FIFO that is not popping (beat dropped)
//   empty             both FIFOs empty
//   a_head, b_head    head payloads (only with AXI_CMP_CAPTURE_EN)
module cmp_chan #(
  parameter int unsigned PW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          a_push,
  input  logic [PW-1:0] a_pl,
  input  logic          b_push,
  input  logic [PW-1:0] b_pl,
  output logic          mism,
  output logic          ovf,
`ifdef AXI_CMP_CAPTURE_EN
  output logic [PW-1:0] a_head,
  output logic [PW-1:0] b_head,
`endif
  output logic          empty
);

  localparam int unsigned IW   = $clog2(DEPTH);
  localparam int unsigned PTRW = IW + 1;

  logic [PW-1:0]   mem_a [DEPTH];
  logic [PW-1:0]   mem_b [DEPTH];
  logic [PTRW-1:0] a_wp, a_rp, b_wp, b_rp;
  logic [PW-1:0]   a_hd, b_hd;
  logic            a_empty, b_empty, a_full, b_full;
  logic            pop, a_wr, b_wr;

  always_comb begin
    a_empty = (a_wp == a_rp);
    b_empty = (b_wp == b_rp);
    a_full  = (a_wp[IW] != a_rp[IW]) && (a_wp[IW-1:0] == a_rp[IW-1:0]);
    b_full  = (b_wp[IW] != b_rp[IW]) && (b_wp[IW-1:0] == b_rp[IW-1:0]);
    pop     = !a_empty && !b_empty;
    // A full FIFO that pops this cycle frees its head slot, so the push lands.
    a_wr    = a_push && (!a_full || pop);
    b_wr    = b_push && (!b_full || pop);
    ovf     = (a_push && a_full && !pop) || (b_push && b_full && !pop);
    a_hd    = mem_a[a_rp[IW-1:0]];
    b_hd    = mem_b[b_rp[IW-1:0]];
    mism    = pop && (a_hd != b_hd);
    empty   = a_empty && b_empty;
  end

`ifdef AXI_CMP_CAPTURE_EN
  assign a_head = a_hd;
  assign b_head = b_hd;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_wp <= '0;
      a_rp <= '0;
      b_wp <= '0;
      b_rp <= '0;
    end else begin
      if (a_wr) a_wp <= a_wp + PTRW'(1);
      if (b_wr) b_wp <= b_wp + PTRW'(1);
      if (pop) begin
        a_rp <= a_rp + PTRW'(1);
        b_rp <= b_rp + PTRW'(1);
      end
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (a_wr) mem_a[a_wp[IW-1:0]] <= a_pl;
    if (b_wr) mem_b[b_wp[IW-1:0]] <= b_pl;
  end

endmodule

// File: rtl/axi_wr_lockstep_cmp.sv
// axi_wr_lockstep_cmp: transaction-level lockstep comparator for two AXI
// write-channel implementations driven with identical stimulus.
// Each channel (AW, W, B) is compared pair-by-pair through a cmp_chan
// skew FIFO; this level keeps the sticky status.
// Ports:
//   clk, resetn             clock, async active-low reset
//   clear                   sync clear of sticky flags, counter, capture
//   a_*/b_*                 side A / side B AW, W, B channel signals
//   mismatch                sticky: some compared pair differed
//   mismatch_chan           {B,W,AW} one-hot(s) of the first mismatch
//   skew_err                sticky: a beat was dropped on a full FIFO
//   mismatch_cnt            saturating count of mismatching pairs
//   in_sync                 all six FIFOs empty
// Optional (macro AXI_CMP_CAPTURE_EN):
//   cap_a, cap_b, cap_valid head payloads of the first mismatch, zero-extended
module axi_wr_lockstep_cmp
  import axi_cmp_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 64,
  parameter int unsigned LENW  = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            clear,
  input  logic [AW-1:0]   a_awaddr,
  input  logic [LENW-1:0] a_awlen,
  input  logic [2:0]      a_awsize,
  input  logic [1:0]      a_awburst,
  input  logic            a_awvalid,
  input  logic            a_awready,
  input  logic [DW-1:0]   a_wdata,
  input  logic [DW/8-1:0] a_wstrb,
  input  logic            a_wlast,
  input  logic            a_wvalid,
  input  logic            a_wready,
  input  logic [1:0]      a_bresp,
  input  logic            a_bvalid,
  input  logic            a_bready,
  input  logic [AW-1:0]   b_awaddr,
  input  logic [LENW-1:0] b_awlen,
  input  logic [2:0]      b_awsize,
  input  logic [1:0]      b_awburst,
  input  logic            b_awvalid,
  input  logic            b_awready,
  input  logic [DW-1:0]   b_wdata,
  input  logic [DW/8-1:0] b_wstrb,
  input  logic            b_wlast,
  input  logic            b_wvalid,
  input  logic            b_wready,
  input  logic [1:0]      b_bresp,
  input  logic            b_bvalid,
  input  logic            b_bready,
  output logic            mismatch,
  output logic [2:0]      mismatch_chan,
  output logic            skew_err,
  output logic [CNTW-1:0] mismatch_cnt,
`ifdef AXI_CMP_CAPTURE_EN
  output logic [cap_width(AW, LENW, DW)-1:0] cap_a,
  output logic [cap_width(AW, LENW, DW)-1:0] cap_b,
  output logic            cap_valid,
`endif
  output logic            in_sync
);

  localparam int unsigned AW_PL = aw_pl_width(AW, LENW);
  localparam int unsigned W_PL  = w_pl_width(DW);
  localparam int unsigned B_PL  = b_pl_width();

  logic [AW_PL-1:0] aw_pl_a, aw_pl_b;
  logic [W_PL-1:0]  w_pl_a, w_pl_b;
  logic [B_PL-1:0]  b_pl_a, b_pl_b;
  logic [2:0]       m, ovf, empty;
  logic [1:0]       n_mism;
  logic [CNTW:0]    cnt_sum;
  logic [CNTW-1:0]  cnt_next;

  assign aw_pl_a = {a_awaddr, a_awlen, a_awsize, a_awburst};
  assign aw_pl_b = {b_awaddr, b_awlen, b_awsize, b_awburst};
  assign w_pl_a  = {a_wdata, a_wstrb, a_wlast};
  assign w_pl_b  = {b_wdata, b_wstrb, b_wlast};
  assign b_pl_a  = a_bresp;
  assign b_pl_b  = b_bresp;

`ifdef AXI_CMP_CAPTURE_EN
  localparam int unsigned CAP_W = cap_width(AW, LENW, DW);
  logic [AW_PL-1:0] aw_hd_a, aw_hd_b;
  logic [W_PL-1:0]  w_hd_a, w_hd_b;
  logic [B_PL-1:0]  b_hd_a, b_hd_b;
`endif

  cmp_chan #(.PW(AW_PL), .DEPTH(DEPTH)) u_aw (
    .clk    (clk),
    .resetn (resetn),
    .a_push (a_awvalid && a_awready),
    .a_pl   (aw_pl_a),
    .b_push (b_awvalid && b_awready),
    .b_pl   (aw_pl_b),
    .mism   (m[CH_AW]),
    .ovf    (ovf[CH_AW]),
`ifdef AXI_CMP_CAPTURE_EN
    .a_head (aw_hd_a),
    .b_head (aw_hd_b),
`endif
    .empty  (empty[CH_AW])
  );

  cmp_chan #(.PW(W_PL), .DEPTH(DEPTH)) u_w (
    .clk    (clk),
    .resetn (resetn),
    .a_push (a_wvalid && a_wready),
    .a_pl   (w_pl_a),
    .b_push (b_wvalid && b_wready),
    .b_pl   (w_pl_b),
    .mism   (m[CH_W]),
    .ovf    (ovf[CH_W]),
`ifdef AXI_CMP_CAPTURE_EN
    .a_head (w_hd_a),
    .b_head (w_hd_b),
`endif
    .empty  (empty[CH_W])
  );

  cmp_chan #(.PW(B_PL), .DEPTH(DEPTH)) u_b (
    .clk    (clk),
    .resetn (resetn),
    .a_push (a_bvalid && a_bready),
    .a_pl   (b_pl_a),
    .b_push (b_bvalid && b_bready),
    .b_pl   (b_pl_b),
    .mism   (m[CH_B]),
    .ovf    (ovf[CH_B]),
`ifdef AXI_CMP_CAPTURE_EN
    .a_head (b_hd_a),
    .b_head (b_hd_b),
`endif
    .empty  (empty[CH_B])
  );

  assign in_sync = &empty;

  // At most 3 added per cycle, so a carry out of CNTW bits means saturation.
  always_comb begin
    n_mism   = 2'(m[0]) + 2'(m[1]) + 2'(m[2]);
    cnt_sum  = {1'b0, mismatch_cnt} + (CNTW + 1)'(n_mism);
    cnt_next = cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mismatch      <= 1'b0;
      mismatch_chan <= '0;
      skew_err      <= 1'b0;
      mismatch_cnt  <= '0;
    end else if (clear) begin
      mismatch      <= 1'b0;
      mismatch_chan <= '0;
      skew_err      <= 1'b0;
      mismatch_cnt  <= '0;
    end else begin
      if (|m) mismatch <= 1'b1;
      if (mismatch_chan == '0) mismatch_chan <= m;
      if (|ovf) skew_err <= 1'b1;
      mismatch_cnt <= cnt_next;
    end
  end

`ifdef AXI_CMP_CAPTURE_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cap_a     <= '0;
      cap_b     <= '0;
      cap_valid <= 1'b0;
    end else if (clear) begin
      cap_a     <= '0;
      cap_b     <= '0;
      cap_valid <= 1'b0;
    end else if (!cap_valid && (|m)) begin
      cap_valid <= 1'b1;
      if (m[CH_AW]) begin
        cap_a <= CAP_W'(aw_hd_a);
        cap_b <= CAP_W'(aw_hd_b);
      end else if (m[CH_W]) begin
        cap_a <= CAP_W'(w_hd_a);
        cap_b <= CAP_W'(w_hd_b);
      end else begin
        cap_a <= CAP_W'(b_hd_a);
        cap_b <= CAP_W'(b_hd_b);
      end
    end
  end
`endif

endmodule
